frame_capture_to_bram: RTL and testbench

Snapshot capture controller that writes one complete video frame from a streaming pixel source into a single-port write side of a frame BRAM, then holds a send-enable level high long enough for the downstream BRAM-to-UART readout stage to dump the whole buffer over serial. It sits directly upstream of the readout block: it drives the BRAM write port and the readout's send-enable input, while the readout owns the BRAM read port.

---
 rtl/frame_capture_to_bram_if.sv | 37 +++
 rtl/frame_capture_to_bram.sv | 148 ++++++++++++++
 tb/tb_frame_capture_to_bram.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_to_bram_if.sv
// ============================================================================
// Module      : frame_capture_to_bram_if
// Description : Pixel-stream input and BRAM write-port bundle for the frame
//               capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_capture_to_bram_if #(
  parameter int BRAM_WIDTH = 24,
  parameter int ADDR_WIDTH = 17
) ();

  logic                  pixel_valid_in;
  logic [10:0]           hcount_in;
  logic [9:0]            vcount_in;
  logic [BRAM_WIDTH-1:0] pixel_in;

  logic                  bram_we_out;
  logic [ADDR_WIDTH-1:0] bram_addr_out;
  logic [BRAM_WIDTH-1:0] bram_data_out;

  // Pixel source plus BRAM consumer side
  modport master (
    output pixel_valid_in, hcount_in, vcount_in, pixel_in,
    input  bram_we_out, bram_addr_out, bram_data_out
  );

  // Capture controller side
  modport slave (
    input  pixel_valid_in, hcount_in, vcount_in, pixel_in,
    output bram_we_out, bram_addr_out, bram_data_out
  );

endinterface

`default_nettype wire

// File: rtl/frame_capture_to_bram.sv
// ============================================================================
// Module      : frame_capture_to_bram
// Description : Captures one video frame into a BRAM write port, then holds
//               the readout send-enable high long enough to dump the buffer.
//               Define DOWNSAMPLE_EN to capture a 2x-resolution source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_capture_to_bram #(
  parameter int BRAM_WIDTH   = 24,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int BAUD_RATE    = 3000000,
  parameter int CLK_FREQ     = 100000000,
  parameter int HOLD_MARGIN  = 1024
) (
  input  wire logic               clk_in,
  input  wire logic               rst_in,
  input  wire logic               capture_in,
  frame_capture_to_bram_if.slave  bus,
  output logic                    send_data_out,
  output logic                    busy_out
);

  localparam int unsigned DEPTH  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  // Ten UART bit times per byte of every stored entry, plus slack
  localparam int unsigned HOLD   = DEPTH * (BRAM_WIDTH / 8) * 10 * (CLK_FREQ / BAUD_RATE)
                                   + HOLD_MARGIN;
  localparam int unsigned CNT_W  = $clog2(HOLD + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BRAM_WIDTH-1:0] data_q;
  logic                  send_q;
  logic                  busy_q;

  logic                  w_frame_start;
  logic                  w_accept;
  logic                  w_last;
  logic [ADDR_W-1:0]     addr_d;

  assign w_frame_start = bus.pixel_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);

`ifdef DOWNSAMPLE_EN
  // Keep only even source coordinates; halving them gives the stored position
  always_comb begin
    w_accept = bus.pixel_valid_in && !bus.hcount_in[0] && !bus.vcount_in[0]
               && (32'(bus.hcount_in) < 2 * FRAME_WIDTH)
               && (32'(bus.vcount_in) < 2 * FRAME_HEIGHT);
    w_last   = (32'(bus.hcount_in) == 2 * FRAME_WIDTH - 2)
               && (32'(bus.vcount_in) == 2 * FRAME_HEIGHT - 2);
    addr_d   = ADDR_W'(bus.vcount_in[9:1]) * ADDR_W'(FRAME_WIDTH)
               + ADDR_W'(bus.hcount_in[10:1]);
  end
`else
  always_comb begin
    w_accept = bus.pixel_valid_in
               && (32'(bus.hcount_in) < FRAME_WIDTH)
               && (32'(bus.vcount_in) < FRAME_HEIGHT);
    w_last   = (32'(bus.hcount_in) == FRAME_WIDTH - 1)
               && (32'(bus.vcount_in) == FRAME_HEIGHT - 1);
    addr_d   = ADDR_W'(bus.vcount_in) * ADDR_W'(FRAME_WIDTH) + ADDR_W'(bus.hcount_in);
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // busy drops here in step with send, unless a new request arrives
          send_q <= 1'b0;
          busy_q <= capture_in;
          if (capture_in) begin
            state_q <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (w_frame_start) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= bus.pixel_in;
            state_q <= w_last ? ST_SETTLE : ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          // A repeated frame start simply maps back to address 0
          if (w_accept) begin
            we_q   <= 1'b1;
            addr_q <= addr_d;
            data_q <= bus.pixel_in;
            if (w_last) begin
              state_q <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          cnt_q   <= '0;
          state_q <= ST_SEND;
        end

        ST_SEND: begin
          send_q <= 1'b1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(HOLD - 1)) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bram_we_out   = we_q;
  assign bus.bram_addr_out = addr_q;
  assign bus.bram_data_out = data_q;
  assign send_data_out     = send_q;
  assign busy_out          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_capture_to_bram.sv
// ============================================================================
// Module      : tb_frame_capture_to_bram
// Description : Randomized bench for frame_capture_to_bram on a 4x3 frame,
//               checked cycle by cycle against a behavioural frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_capture_to_bram;

  localparam int FW   = 4;
  localparam int FH   = 3;
  localparam int BW   = 24;
  localparam int AW   = 4;
  localparam int HOLD = 1456;
  localparam int MAXE = 4096;
`ifdef DOWNSAMPLE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap = 1'b0;
  logic send, busy;

  frame_capture_to_bram_if #(.BRAM_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  frame_capture_to_bram #(
    .BRAM_WIDTH(BW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
    .BAUD_RATE(1), .CLK_FREQ(4), .HOLD_MARGIN(16)
  ) dut (
    .clk_in(clk), .rst_in(rst), .capture_in(cap), .bus(bus),
    .send_data_out(send), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus log and observations, indexed by clock edge within a run
  bit          s_valid[MAXE];
  bit          s_cap[MAXE];
  int          s_h[MAXE];
  int          s_v[MAXE];
  logic [23:0] s_pix[MAXE];

  logic        obs_we[MAXE];
  logic [3:0]  obs_addr[MAXE];
  logic [23:0] obs_data[MAXE];
  logic        obs_send[MAXE];
  logic        obs_busy[MAXE];

  bit          exp_we[MAXE];
  int          exp_addr[MAXE];
  logic [23:0] exp_data[MAXE];
  bit          exp_send[MAXE];
  bit          exp_busy[MAXE];

  int edge_cnt = 0;
  int base = 0;
  bit rec = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin : monitor
    int e;
    e = edge_cnt - base - 1;
    if (rec && e >= 0 && e < MAXE) begin
      obs_we[e]   = bus.bram_we_out;
      obs_addr[e] = bus.bram_addr_out;
      obs_data[e] = bus.bram_data_out;
      obs_send[e] = send;
      obs_busy[e] = busy;
    end
  end

  // Reference mapping of a source pixel to the stored frame
  function automatic bit acc(int e);
    if (!s_valid[e]) return 1'b0;
    if (SC == 2 && ((s_h[e] % 2) != 0 || (s_v[e] % 2) != 0)) return 1'b0;
    return (s_h[e] < SC * FW) && (s_v[e] < SC * FH);
  endfunction

  function automatic bit is_last(int e);
    return (s_h[e] == SC * FW - SC) && (s_v[e] == SC * FH - SC);
  endfunction

  function automatic bit is_start(int e);
    return s_valid[e] && s_h[e] == 0 && s_v[e] == 0;
  endfunction

  function automatic int addr_of(int e);
    return (s_v[e] / SC) * FW + (s_h[e] / SC);
  endfunction

  // Transfers: capture -> first frame start -> every stored pixel up to the
  // last one -> send window of HOLD cycles starting two cycles after it
  task automatic model(input int n);
    int from, c, s, l, endb, wend;
    for (int e = 0; e < n; e++) begin
      exp_we[e] = 0; exp_addr[e] = 0; exp_data[e] = '0; exp_send[e] = 0; exp_busy[e] = 0;
    end
    from = 0;
    while (from < n) begin
      c = -1;
      for (int e = from; e < n; e++) if (s_cap[e]) begin c = e; break; end
      if (c < 0) break;
      s = -1;
      for (int e = c + 1; e < n; e++) if (is_start(e)) begin s = e; break; end
      l = -1;
      if (s >= 0)
        for (int e = s; e < n; e++) if (acc(e) && is_last(e)) begin l = e; break; end
      endb = (l >= 0) ? l + 1 + HOLD : n - 1;
      for (int e = c; e <= endb && e < n; e++) exp_busy[e] = 1;
      if (s >= 0) begin
        wend = (l >= 0) ? l : n - 1;
        for (int e = s; e <= wend; e++)
          if (acc(e)) begin
            exp_we[e] = 1; exp_addr[e] = addr_of(e); exp_data[e] = s_pix[e];
          end
      end
      if (l >= 0)
        for (int e = l + 2; e <= l + 1 + HOLD && e < n; e++) exp_send[e] = 1;
      from = endb + 1;
    end
  endtask

  task automatic compare(input int n, output int nw, output int ns, output int first);
    nw = 0; ns = 0; first = -1;
    for (int e = 0; e < n - 1; e++) begin
      check($sformatf("we[%0d]", e), 64'(obs_we[e]), 64'(exp_we[e]));
      if (exp_we[e]) begin
        check($sformatf("addr[%0d]", e), 64'(obs_addr[e]), 64'(exp_addr[e]));
        check($sformatf("data[%0d]", e), 64'(obs_data[e]), 64'(exp_data[e]));
      end
      check($sformatf("send[%0d]", e), 64'(obs_send[e]), 64'(exp_send[e]));
      check($sformatf("busy[%0d]", e), 64'(obs_busy[e]), 64'(exp_busy[e]));
      if (obs_we[e] === 1'b1) begin
        if (first < 0) first = e;
        nw++;
      end
      if (obs_send[e] === 1'b1) ns++;
    end
  endtask

  task automatic do_reset();
    rec = 1'b0;
    rst = 1'b1;
    bus.pixel_valid_in = 1'b0;
    cap = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams a raster source of sw x sh starting mid-frame at (1,1)
  task automatic run(input int n, input int sw, input int sh, input int gap_pct,
                     input int drop_pct, input bit ramp, input int c0, input int c1,
                     input int c2, input int c3, input bit stop5, output int n_used);
    int h, v;
    h = 1; v = 1;
    n_used = n;
    @(negedge clk);
    base = edge_cnt;
    rec = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (stop5 && bus.bram_we_out === 1'b1 && bus.bram_addr_out === 4'd5) begin
        n_used = i;
        break;
      end
      s_cap[i] = (i == c0) || (i == c1) || (i == c2) || (i == c3);
      if ($urandom_range(0, 99) < drop_pct) begin
        h++; if (h == sw) begin h = 0; v++; if (v == sh) v = 0; end
      end
      if ($urandom_range(0, 99) < gap_pct) begin
        s_valid[i] = 1'b0;
        s_h[i] = $urandom_range(0, 15);
        s_v[i] = $urandom_range(0, 15);
        s_pix[i] = 24'($urandom);
      end else begin
        s_valid[i] = 1'b1;
        s_h[i] = h;
        s_v[i] = v;
        s_pix[i] = ramp ? 24'(v * 16 + h) : 24'($urandom);
        h++; if (h == sw) begin h = 0; v++; if (v == sh) v = 0; end
      end
      cap = s_cap[i];
      bus.pixel_valid_in = s_valid[i];
      bus.hcount_in = 11'(s_h[i]);
      bus.vcount_in = 10'(s_v[i]);
      bus.pixel_in = s_pix[i];
    end
    if (stop5 && n_used == n) check("reach_addr5", 64'(0), 64'(1));
    cap = 1'b0;
    bus.pixel_valid_in = 1'b0;
    #1;
  endtask

  initial begin
    int nu, nw, ns, first;
    bus.pixel_valid_in = 1'b0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.pixel_in = '0;
    repeat (3) @(negedge clk);
    check("rst_we", 64'(bus.bram_we_out), 64'(0));
    check("rst_addr", 64'(bus.bram_addr_out), 64'(0));
    check("rst_data", 64'(bus.bram_data_out), 64'(0));
    check("rst_send", 64'(send), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // Idle stream, no request
    run(300, SC * FW, SC * FH, 20, 0, 1'b0, -1, -1, -1, -1, 1'b0, nu);
    model(nu); compare(nu, nw, ns, first);
    check("idle_writes", 64'(nw), 64'(0));

    // Request mid-frame with ramp pixels
    do_reset();
    run(1600, SC * FW, SC * FH, 0, 0, 1'b1, 7, -1, -1, -1, 1'b0, nu);
    model(nu); compare(nu, nw, ns, first);
    check("ramp_writes", 64'(nw), 64'(12));
    check("ramp_send_len", 64'(ns), 64'(HOLD));

    // Oversized source, gaps, requests during capture/send and a second transfer
    do_reset();
    run(3600, SC * 6, SC * 5, 25, 0, 1'b0, 3, 60, 900, 1700, 1'b0, nu);
    model(nu); compare(nu, nw, ns, first);

    // Source dropping pixels
    do_reset();
    run(2400, SC * 6, SC * 5, 10, 5, 1'b0, 5, -1, -1, -1, 1'b0, nu);
    model(nu); compare(nu, nw, ns, first);

    // Reset in the middle of a capture
    do_reset();
    run(300, SC * FW, SC * FH, 0, 0, 1'b0, 2, -1, -1, -1, 1'b1, nu);
    model(nu); compare(nu, nw, ns, first);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 64'(bus.bram_we_out), 64'(0));
    check("arst_addr", 64'(bus.bram_addr_out), 64'(0));
    check("arst_data", 64'(bus.bram_data_out), 64'(0));
    check("arst_send", 64'(send), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    do_reset();

    // Fresh capture after the interrupted one
    run(1600, SC * FW, SC * FH, 15, 0, 1'b0, 4, -1, -1, -1, 1'b0, nu);
    model(nu); compare(nu, nw, ns, first);
    check("restart_writes", 64'(nw), 64'(12));
    if (first >= 0) check("restart_first_addr", 64'(obs_addr[first]), 64'(0));
    else check("restart_any_write", 64'(0), 64'(1));

    rec = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
